tpu_job_scheduler: RTL
======================

# tpu_job_scheduler

Sequences complete matrix jobs through the 2x2 systolic datapath and shares it between NREQ requesters. Arbitrates round-robin, streams the granted requester's 8 operand bytes into operand memory, clears and runs the array for a fixed compute window, then drains 8 result bytes back to the owner under valid/ready. Sits between the host-facing request ports and the memory/control/array cluster, replacing per-pin manual sequencing.

## Interface
- NREQ, 2: number of requesters (2..4)
- COMPUTE_CYCLES, 6: cycles the array runs after clear before results are read
- TIMEOUT, 255: load-stall watchdog limit in cycles (used only with SCHED_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester job request, level, held until its grant
- req_cfg  in  2*NREQ  per-requester {activation, transpose}, sampled at grant
- grant  out  NREQ  one-hot owner of the datapath, held for the whole job
- in_valid  in  1  operand byte valid from the owner
- in_data  in  8  operand byte
- in_ready  out  1  operand byte accepted when in_valid&&in_ready
- load_en  out  1  memory write strobe
- mem_addr  out  3  memory/result byte address
- mem_data  out  8  byte to memory (= in_data)
- mmu_clear  out  1  accumulator clear
- mmu_transpose, mmu_activation  out  1 each  latched job config
- res_data  in  8  result byte selected by mem_addr (combinational from the array)
- out_valid  out  1  result byte valid
- out_data  out  8  result byte (= res_data)
- out_ready  in  1  owner accepts result byte
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse on watchdog abort (tied 0 without macro)

## Operation
- States: IDLE, LOAD, CLEAR, COMPUTE, DRAIN, DONE.
- IDLE: if any req, the round-robin pick (first requester strictly after last winner, wrapping) gets grant; req_cfg latched; byte counter=0; -> LOAD.
- LOAD: in_ready=1; each accepted byte drives load_en=1, mem_addr=count, mem_data=in_data the same cycle; count increments; 8th accept -> CLEAR.
- CLEAR: mmu_clear=1 for exactly one cycle; -> COMPUTE.
- COMPUTE: counts COMPUTE_CYCLES cycles; -> DRAIN with count=0.
- DRAIN: out_valid=1, mem_addr=count, out_data=res_data; advances on out_ready; 8th handshake -> DONE.
- DONE: done=1, grant drops next cycle, last winner updated; -> IDLE.
- Requests changing mid-job are ignored; only IDLE arbitrates. Deasserting req of the owner does not abort the job.
- out_valid and in_ready never both 1; load_en only in LOAD.

## Timing
- Reset values: grant=0, in_ready=0, load_en=0, mem_addr=0, mmu_clear=0, mmu_transpose=0, mmu_activation=0, out_valid=0, done=0, err=0; state IDLE; last-winner pointer=NREQ-1 (requester 0 wins first).
- grant asserts the cycle after req seen in IDLE, deasserts the cycle after done.
- Minimum job with no back-pressure: 1 + 8 + 1 + COMPUTE_CYCLES + 8 + 1 = 25 cycles at defaults; next grant earliest 1 cycle after DONE.
- Stalls (in_valid=0 or out_ready=0) hold count and mem_addr; no byte lost or duplicated.
- mem_addr wraps 7->0 only via state transition, never mid-phase.
- Reset mid-job: immediate return to IDLE, all outputs to reset values, partial memory contents undefined.

## Configuration
- SCHED_TIMEOUT_EN defined: in LOAD a stall counter counts consecutive cycles without an accepted byte; reaching TIMEOUT pulses err for one cycle, drops grant, returns IDLE without CLEAR/COMPUTE; pointer still advances past the aborted owner.
- Undefined: no watchdog logic; LOAD waits indefinitely; err tied 0.

## Structure
- Package tpu_sched_pkg: state enum, BYTES_PER_JOB=8, address width 3, config bit positions within req_cfg.
- Sub-module tpu_rr_arbiter: combinational one-hot pick from req and last-winner pointer plus pointer register updated on a strobe from DONE/abort.

## Test plan
- Single job, req=01, bytes 1..8, COMPUTE_CYCLES=6, out_ready=1 -> load_en at addrs 0..7, one mmu_clear, out_valid addrs 0..7, done at cycle 25 after req.
- req=11 held continuously -> grants alternate 01,10,01,10 across four jobs.
- in_valid toggling 1/0 and out_ready 0 for 3 cycles at byte 4 -> mem_addr holds, exactly 8 writes and 8 reads, no duplicate addresses.
- req_cfg={1,1} for requester 1 -> mmu_transpose=mmu_activation=1 for whole job, back to latched value 0 for next requester-0 job.
- rst_n low during COMPUTE -> all outputs 0 asynchronously, next req=10 granted to requester 0 rule (pointer reset): req=11 grants 01.
- SCHED_TIMEOUT_EN, TIMEOUT=255, in_valid stops after 3 bytes -> err pulse 255 cycles later, grant drops, no mmu_clear.

Source files
------------

// File: rtl/tpu_sched_pkg.sv
// Shared types and constants for the TPU job scheduler.
package tpu_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CLEAR   = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } sched_state_e;

  localparam int BYTES_PER_JOB = 8;
  localparam int ADDR_W        = 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_JOB - 1);

  // Per-requester slice of req_cfg is {activation, transpose}
  localparam int CFG_W          = 2;
  localparam int CFG_TRANSPOSE  = 0;
  localparam int CFG_ACTIVATION = 1;

endpackage

// File: rtl/tpu_rr_arbiter.sv
// Round-robin pick among requesters, starting strictly after the last winner.
module tpu_rr_arbiter
  import tpu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  output logic [NREQ-1:0]  pick,
  output logic [IDX_W-1:0] pick_idx
);

  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last_idx <= IDX_W'(NREQ - 1);
    else if (upd) last_idx <= upd_idx;
  end

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    cand     = '0;
    found    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last_idx) + i) % NREQ);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tpu_job_scheduler.sv
// Job sequencer for the shared 2x2 systolic array: arbitrate, load, clear, compute, drain.
// Optional load-stall watchdog enabled by defining SCHED_TIMEOUT_EN.
module tpu_job_scheduler
  import tpu_sched_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int COMPUTE_CYCLES = 6,
  parameter int TIMEOUT        = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [CFG_W*NREQ-1:0]  req_cfg,
  output logic [NREQ-1:0]        grant,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   load_en,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_data,
  output logic                   mmu_clear,
  output logic                   mmu_transpose,
  output logic                   mmu_activation,
  input  logic [7:0]             res_data,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic                   done,
  output logic                   err
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CW    = $clog2(COMPUTE_CYCLES + 1);

  sched_state_e      state, state_nxt;
  logic [ADDR_W-1:0] count;
  logic [CW-1:0]     comp_cnt;
  logic [IDX_W-1:0]  owner;
  logic [NREQ-1:0]   pick;
  logic [IDX_W-1:0]  pick_idx;
  logic [CFG_W-1:0]  pick_cfg;
  logic              accept, drain_hs, abort;

  assign accept   = (state == S_LOAD) && in_valid;
  assign drain_hs = (state == S_DRAIN) && out_ready;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;

  // Down-counter reloads on every accepted byte; terminal count aborts the job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             stall_cnt <= TW'(TIMEOUT - 1);
    else if (state != S_LOAD || in_valid)   stall_cnt <= TW'(TIMEOUT - 1);
    else if (stall_cnt != '0)               stall_cnt <= stall_cnt - 1'b1;
  end

  assign abort = (state == S_LOAD) && !in_valid && (stall_cnt == '0);
  assign err   = abort;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  tpu_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .upd      ((state == S_DONE) || abort),
    .upd_idx  (owner),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_comb begin
    pick_cfg = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) pick_cfg = req_cfg[i*CFG_W +: CFG_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|req) state_nxt = S_LOAD;
      S_LOAD: begin
        if (abort)                                state_nxt = S_IDLE;
        else if (accept && count == LAST_ADDR)    state_nxt = S_CLEAR;
      end
      S_CLEAR:   state_nxt = S_COMPUTE;
      S_COMPUTE: if (comp_cnt == '0) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_hs && count == LAST_ADDR) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // count wraps 7->0 exactly on the phase-ending handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count          <= '0;
      comp_cnt       <= '0;
      grant          <= '0;
      owner          <= '0;
      mmu_transpose  <= 1'b0;
      mmu_activation <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          grant          <= pick;
          owner          <= pick_idx;
          mmu_transpose  <= pick_cfg[CFG_TRANSPOSE];
          mmu_activation <= pick_cfg[CFG_ACTIVATION];
          count          <= '0;
        end
        S_LOAD: begin
          if (abort) begin
            grant <= '0;
            count <= '0;
          end else if (accept) begin
            count <= count + 1'b1;
          end
        end
        S_CLEAR:   comp_cnt <= CW'(COMPUTE_CYCLES - 1);
        S_COMPUTE: if (comp_cnt != '0) comp_cnt <= comp_cnt - 1'b1;
        S_DRAIN:   if (out_ready) count <= count + 1'b1;
        S_DONE:    grant <= '0;
        default:   ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    load_en   = 1'b0;
    mmu_clear = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        load_en  = in_valid;
      end
      S_CLEAR: mmu_clear = 1'b1;
      S_DRAIN: out_valid = 1'b1;
      S_DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = count;
  assign mem_data = in_data;
  assign out_data = res_data;

endmodule
